// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO; frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          cpu_clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overrun,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    head;
  logic          push;
  logic          pop;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    sh, sh_nx;
  logic          tx_nx;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par, par_nx;
`endif

  // A full FIFO rejects the write even if the FSM pops on the same edge.
  assign push  = wr_en && !full;
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];
  assign busy  = (state != IDLE);

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Set has priority over clear so a drop on the clearing edge is not lost.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst)                 overrun <= 1'b0;
    else if (wr_en && full)  overrun <= 1'b1;
    else if (clr_ovr)        overrun <= 1'b0;
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      sh       <= sh_nx;
      tx       <= tx_nx;
`ifdef UART_TX_PARITY_EN
      par      <= par_nx;
`endif
    end
  end

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    sh_nx    = sh;
    tx_nx    = tx;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx   = par;
`endif
    // Baud counter restarts at every bit boundary so each bit is exact.
    if (state != IDLE) baud_nx = bit_end ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          sh_nx    = head;
          tx_nx    = 1'b0;
          state_nx = START;
`ifdef UART_TX_PARITY_EN
          par_nx   = ^head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          tx_nx    = sh[0];
          bit_nx   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
            tx_nx    = par;
`else
            state_nx = STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            bit_nx = bit_idx + 1'b1;
            sh_nx  = {1'b0, sh[7:1]};
            tx_nx  = sh[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          tx_nx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop      = 1'b1;
            sh_nx    = head;
            tx_nx    = 1'b0;
            state_nx = START;
`ifdef UART_TX_PARITY_EN
            par_nx   = ^head;
`endif
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honors UART_TX_PARITY_EN: frames then carry an even-parity bit (11 bits).
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       cpu_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovr = 1'b0;
  logic       full, empty, busy, overrun, tx;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovr (clr_ovr),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .busy    (busy),
    .overrun (overrun),
    .tx      (tx)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    wr_data = ~d;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Entered just after the edge that started the frame; returns at the same
  // phase one frame later, i.e. aligned with a back-to-back next frame.
  task automatic check_frame(input logic [7:0] d, input string tag);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c % CPB == 1) check($sformatf("%s_bit%0d", tag, c / CPB), tx, exp_bit(d, c / CPB));
      if (c == 0)           check({tag, "_start_low"}, tx, 1'b0);
      if (c == FRAME_CYC-1) check({tag, "_busy_last"}, busy, 1'b1);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int lows;

    // Reset state
    tick(); tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_level", level, 3'd0);
    check("rst_overrun", overrun, 1'b0);
    @(negedge cpu_clk) rst = 1'b0;
    tick(); tick();

    // 1: single byte 0x55
    push_byte(8'h55);
    check("t1_level_after_wr", level, 3'd1);
    check("t1_tx_still_idle", tx, 1'b1);
    check("t1_busy_before", busy, 1'b0);
    tick();
    check("t1_level_popped", level, 3'd0);
    check("t1_empty_popped", empty, 1'b1);
    check_frame(8'h55, "t1");
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_tx", tx, 1'b1);
    tick(); tick();

    // 2: back-to-back 0xA3, 0x0F
    push_byte(8'hA3);
    push_byte(8'h0F);
    check_frame(8'hA3, "t2a");
    check_frame(8'h0F, "t2b");
    check("t2_idle_busy", busy, 1'b0);
    check("t2_idle_tx", tx, 1'b1);
    tick(); tick();

    // 3: fill while idle, first byte pops at the second write edge
    push_byte(8'h11);
    a = cyc;
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h66);
    check("t3_level_peak", level, 3'd4);
    check("t3_full", full, 1'b1);
    check("t3_no_overrun", overrun, 1'b0);
    push_byte(8'h99);
    check("t3_overrun_set", overrun, 1'b1);
    check("t3_level_kept", level, 3'd4);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("t3_overrun_clr", overrun, 1'b0);
    wr_data = 8'h98; wr_en = 1'b1; clr_ovr = 1'b1; tick();
    wr_en = 1'b0; clr_ovr = 1'b0;
    check("t3_set_wins", overrun, 1'b1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("t3_overrun_clr2", overrun, 1'b0);

    // 4: write on the STOP pop edge with the FIFO full
    while (cyc < a + FRAME_CYC) tick();
    check("t4_full_before", full, 1'b1);
    check("t4_busy_before", busy, 1'b1);
    push_byte(8'h77);
    check("t4_overrun", overrun, 1'b1);
    check("t4_level", level, 3'd3);
    check("t4_full_after", full, 1'b0);
    check_frame(8'h22, "t4a");
    check_frame(8'h33, "t4b");
    check_frame(8'h44, "t4c");
    check_frame(8'h66, "t4d");
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_tx", tx, 1'b1);
    check("t4_overrun_sticky", overrun, 1'b1);

    // 5: async reset mid-DATA
    push_byte(8'hFF);
    push_byte(8'h12);
    for (int i = 0; i < 14; i++) tick();
    check("t5_tx_data", tx, 1'b1);
    check("t5_busy_data", busy, 1'b1);
    check("t5_level_data", level, 3'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_level", level, 3'd0);
    check("t5_rst_empty", empty, 1'b1);
    check("t5_rst_overrun", overrun, 1'b0);
    tick();
    @(negedge cpu_clk) rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_no_frame", lows, 0);

    // 6: parity-sensitive bytes
    push_byte(8'h07);
    push_byte(8'h03);
    check_frame(8'h07, "t6a");
    check_frame(8'h03, "t6b");
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_tx", tx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
